addsub_sat_pipe: RTL and testbench

ADDSUB_SAT_PIPE -- requirements
Module: addsub_sat_pipe

---
 rtl/addsub_sat_pipe.sv | 114 +++++++++++
 tb/tb_addsub_sat_pipe.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/addsub_sat_pipe.sv
// Pipelined signed add/subtract with optional saturation, valid chain,
// clock enable and a saturating 16-bit overflow counter.
module addsub_sat_pipe #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned LATENCY  = 2,
  parameter int unsigned SATURATE = 1
) (
  input  logic             CLK,
  input  logic             SCLR,
  input  logic             CE,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             ADD,
  input  logic             IN_VALID,
  input  logic             CNT_CLR,
  output logic [WIDTH-1:0] S,
  output logic             OUT_VALID,
  output logic             OVF,
  output logic [15:0]      OVF_CNT
);

  localparam int unsigned XW    = WIDTH + 1;
  localparam int unsigned CNT_W = 16;

  logic [XW-1:0]    w_a_ext;
  logic [XW-1:0]    w_b_ext;
  logic [XW-1:0]    w_exact;
  logic             w_ovf;
  logic [WIDTH-1:0] w_clamp;
  logic [WIDTH-1:0] w_res;

  logic             w_pv;
  logic             w_po;
  logic [WIDTH-1:0] w_ps;
  logic             w_load_ovf;

  logic [WIDTH-1:0] r_s;
  logic             r_out_valid;
  logic             r_ovf;
  logic [CNT_W-1:0] r_ovf_cnt;

  // Exact result in WIDTH+1 bits; the sign of the exact result picks the clamp rail.
  assign w_a_ext = {A[WIDTH-1], A};
  assign w_b_ext = {B[WIDTH-1], B};
  assign w_exact = ADD ? (w_a_ext + w_b_ext) : (w_a_ext - w_b_ext);
  assign w_ovf   = w_exact[XW-1] ^ w_exact[WIDTH-1];
  assign w_clamp = w_exact[XW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
  assign w_res   = ((SATURATE != 0) && w_ovf) ? w_clamp : w_exact[WIDTH-1:0];

  // LATENCY-1 delay stages between the arithmetic and the output register.
  generate
    if (LATENCY > 1) begin : g_pipe
      localparam int unsigned N = LATENCY - 1;
      logic [N-1:0]     r_v;
      logic [N-1:0]     r_o;
      logic [WIDTH-1:0] r_d [N];

      always_ff @(posedge CLK) begin
        if (SCLR) begin
          r_v <= '0;
          r_o <= '0;
          for (int i = 0; i < N; i++) r_d[i] <= '0;
        end else if (CE) begin
          r_v[0] <= IN_VALID;
          r_o[0] <= w_ovf;
          r_d[0] <= w_res;
          for (int i = 1; i < N; i++) begin
            r_v[i] <= r_v[i-1];
            r_o[i] <= r_o[i-1];
            r_d[i] <= r_d[i-1];
          end
        end
      end

      assign w_pv = r_v[N-1];
      assign w_po = r_o[N-1];
      assign w_ps = r_d[N-1];
    end else begin : g_direct
      assign w_pv = IN_VALID;
      assign w_po = w_ovf;
      assign w_ps = w_res;
    end
  endgenerate

  assign w_load_ovf = CE & w_pv & w_po;

  // Output stage: bubbles clear OVF and leave S untouched; the counter clear ignores CE.
  always_ff @(posedge CLK) begin
    if (SCLR) begin
      r_s         <= '0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_ovf_cnt   <= '0;
    end else begin
      if (CE) begin
        r_out_valid <= w_pv;
        r_ovf       <= w_pv & w_po;
        if (w_pv) r_s <= w_ps;
      end
      if (CNT_CLR) begin
        r_ovf_cnt <= CNT_W'(w_load_ovf);
      end else if (w_load_ovf && (r_ovf_cnt != {CNT_W{1'b1}})) begin
        r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
      end
    end
  end

  assign S         = r_s;
  assign OUT_VALID = r_out_valid;
  assign OVF       = r_ovf;
  assign OVF_CNT   = r_ovf_cnt;

endmodule

// File: tb/tb_addsub_sat_pipe.sv
// Scoreboard bench: two instances (saturating LATENCY=2, wrapping LATENCY=3)
// share stimulus; each has its own expected-result queue and output monitor.
module tb_addsub_sat_pipe;

  logic        CLK = 1'b0;
  logic        SCLR, CE, ADD, IN_VALID, cnt_clr0, cnt_clr1;
  logic [31:0] A, B;

  logic [31:0] s0, s1;
  logic        v0, v1, o0, o1;
  logic [15:0] c0, c1;

  always #5 CLK = ~CLK;

  addsub_sat_pipe #(.WIDTH(32), .LATENCY(2), .SATURATE(1)) u_sat (
    .CLK(CLK), .SCLR(SCLR), .CE(CE), .A(A), .B(B), .ADD(ADD),
    .IN_VALID(IN_VALID), .CNT_CLR(cnt_clr0),
    .S(s0), .OUT_VALID(v0), .OVF(o0), .OVF_CNT(c0)
  );

  addsub_sat_pipe #(.WIDTH(32), .LATENCY(3), .SATURATE(0)) u_wrap (
    .CLK(CLK), .SCLR(SCLR), .CE(CE), .A(A), .B(B), .ADD(ADD),
    .IN_VALID(IN_VALID), .CNT_CLR(cnt_clr1),
    .S(s1), .OUT_VALID(v1), .OVF(o1), .OVF_CNT(c1)
  );

  typedef struct {
    logic [31:0] s;
    logic        ovf;
    int          edge_n;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        add;
    logic [31:0] s_sat;
    logic [31:0] s_wrap;
    logic        ovf;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   ecount = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic mon(input int id, input logic v, input logic [31:0] s, input logic o, input int lat);
    exp_t e;
    if (v) begin
      if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL u%0d_unexpected_out actual=S %0h required=no output", id, s);
      end else begin
        e = (id == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("u%0d_S", id), 64'(s), 64'(e.s));
        chk($sformatf("u%0d_OVF", id), 64'(o), 64'(e.ovf));
        chk($sformatf("u%0d_latency_edge", id), 64'(ecount), 64'(e.edge_n + lat - 1));
      end
    end else begin
      chk($sformatf("u%0d_bubble_OVF", id), 64'(o), 64'd0);
    end
  endtask

  // Monitor: count enabled edges, then compare whatever the output stages loaded.
  always @(posedge CLK) begin : p_mon
    logic en;
    en = CE && !SCLR;
    if (en) ecount++;
    #1;
    if (en) begin
      mon(0, v0, s0, o0, 2);
      mon(1, v1, s1, o1, 3);
    end
  end

  task automatic drive(input logic ce, input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic add, input logic [31:0] s_sat, input logic [31:0] s_wrap,
                       input logic ovf);
    exp_t e;
    @(negedge CLK);
    CE = ce; IN_VALID = v; A = a; B = b; ADD = add;
    if (ce && v && !SCLR) begin
      e.ovf = ovf; e.edge_n = ecount + 1;
      e.s = s_sat;  q0.push_back(e);
      e.s = s_wrap; q1.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) idle(1);
    idle(1);
    chk("drain_pending", 64'(q0.size() + q1.size()), 64'd0);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{32'h7FFFFFF0, 32'h00000020, 1'b1, 32'h7FFFFFFF, 32'h80000010, 1'b1};
    vecs[1] = '{32'h80000000, 32'h00000001, 1'b0, 32'h80000000, 32'h7FFFFFFF, 1'b1};
    vecs[2] = '{32'h80000000, 32'h80000000, 1'b1, 32'h80000000, 32'h00000000, 1'b1};
    vecs[3] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h7FFFFFFF, 32'h80000000, 1'b1};
    vecs[4] = '{32'h00000005, 32'h00000007, 1'b0, 32'hFFFFFFFE, 32'hFFFFFFFE, 1'b0};
    vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'hFFFFFFFE, 1'b0};
    vecs[6] = '{32'h80000000, 32'h7FFFFFFF, 1'b0, 32'h80000000, 32'h00000001, 1'b1};
    vecs[7] = '{32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0};
    vecs[8] = '{32'h80000000, 32'h00000000, 1'b0, 32'h80000000, 32'h80000000, 1'b0};
    vecs[9] = '{32'h40000000, 32'h40000000, 1'b1, 32'h7FFFFFFF, 32'h80000000, 1'b1};
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    SCLR = 1'b1; CE = 1'b0; ADD = 1'b0; IN_VALID = 1'b0;
    cnt_clr0 = 1'b0; cnt_clr1 = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge CLK);
    SCLR = 1'b0;

    // Reset state, established with CE low.
    chk("u0_S_reset", 64'(s0), 64'd0);   chk("u1_S_reset", 64'(s1), 64'd0);
    chk("u0_OV_reset", 64'(v0), 64'd0);  chk("u1_OV_reset", 64'(v1), 64'd0);
    chk("u0_OVF_reset", 64'(o0), 64'd0); chk("u1_OVF_reset", 64'(o1), 64'd0);
    chk("u0_CNT_reset", 64'(c0), 64'd0); chk("u1_CNT_reset", 64'(c1), 64'd0);

    // Decrementing subtract stream, no overflow.
    for (int k = 0; k < 5; k++)
      drive(1'b1, 1'b1, 32'(4000 - 200 * k), 32'h0, 1'b0,
            32'(4000 - 200 * k), 32'(4000 - 200 * k), 1'b0);

    // Boundary vectors with alternating ADD and occasional bubbles.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, vecs[i].a, vecs[i].b, vecs[i].add, vecs[i].s_sat, vecs[i].s_wrap, vecs[i].ovf);
      if (i % 3 == 2) idle(1);
    end
    drain();
    chk("u0_CNT_after_vecs", 64'(c0), 64'd6);
    chk("u1_CNT_after_vecs", 64'(c1), 64'd6);

    // Valid pattern 1,0,1 then CE low for two edges with junk overflow inputs offered.
    drive(1'b1, 1'b1, 32'd100, 32'd23, 1'b1, 32'd123, 32'd123, 1'b0);
    drive(1'b1, 1'b0, 32'h7FFFFFFF, 32'd1, 1'b1, 32'h0, 32'h0, 1'b0);
    drive(1'b1, 1'b1, 32'd50, 32'd8, 1'b0, 32'd42, 32'd42, 1'b0);
    drive(1'b0, 1'b1, 32'h7FFFFFFF, 32'd1, 1'b1, 32'h0, 32'h0, 1'b1);
    drive(1'b0, 1'b1, 32'h80000000, 32'd1, 1'b0, 32'h0, 32'h0, 1'b1);
    drain();
    chk("u0_CNT_after_ce", 64'(c0), 64'd6);

    // SCLR with overflowing samples in flight.
    drive(1'b1, 1'b1, 32'h7FFFFFF0, 32'h20, 1'b1, 32'h7FFFFFFF, 32'h80000010, 1'b1);
    drive(1'b1, 1'b1, 32'h7FFFFFF0, 32'h20, 1'b1, 32'h7FFFFFFF, 32'h80000010, 1'b1);
    @(negedge CLK);
    SCLR = 1'b1; IN_VALID = 1'b0; cnt_clr0 = 1'b0;
    q0.delete(); q1.delete();
    @(negedge CLK);
    SCLR = 1'b0;
    chk("u0_S_sclr", 64'(s0), 64'd0);    chk("u1_S_sclr", 64'(s1), 64'd0);
    chk("u0_OV_sclr", 64'(v0), 64'd0);   chk("u1_OV_sclr", 64'(v1), 64'd0);
    chk("u0_CNT_sclr", 64'(c0), 64'd0);  chk("u1_CNT_sclr", 64'(c1), 64'd0);
    drive(1'b1, 1'b1, 32'h80000000, 32'd1, 1'b0, 32'h80000000, 32'h7FFFFFFF, 1'b1);
    drain();
    chk("u0_CNT_post_sclr", 64'(c0), 64'd1);
    chk("u1_CNT_post_sclr", 64'(c1), 64'd1);

    // Counter clear while idle.
    @(negedge CLK); cnt_clr0 = 1'b1; cnt_clr1 = 1'b1;
    @(negedge CLK); cnt_clr0 = 1'b0; cnt_clr1 = 1'b0;
    chk("u0_CNT_clr", 64'(c0), 64'd0);
    chk("u1_CNT_clr", 64'(c1), 64'd0);

    // Counter saturation.
    for (int i = 0; i < 65535; i++)
      drive(1'b1, 1'b1, 32'h7FFFFFF0, 32'h20, 1'b1, 32'h7FFFFFFF, 32'h80000010, 1'b1);
    drain();
    chk("u0_CNT_full", 64'(c0), 64'hFFFF);
    chk("u1_CNT_full", 64'(c1), 64'hFFFF);
    drive(1'b1, 1'b1, 32'h7FFFFFF0, 32'h20, 1'b1, 32'h7FFFFFFF, 32'h80000010, 1'b1);
    drain();
    chk("u0_CNT_sat", 64'(c0), 64'hFFFF);
    chk("u1_CNT_sat", 64'(c1), 64'hFFFF);

    // Clear on the very edge an overflowed sample reaches each output stage.
    drive(1'b1, 1'b1, 32'h80000000, 32'h80000000, 1'b1, 32'h80000000, 32'h00000000, 1'b1);
    @(negedge CLK); IN_VALID = 1'b0; cnt_clr0 = 1'b1;
    @(negedge CLK); cnt_clr0 = 1'b0; cnt_clr1 = 1'b1;
    @(negedge CLK); cnt_clr1 = 1'b0;
    drain();
    chk("u0_CNT_clr_with_ovf", 64'(c0), 64'd1);
    chk("u1_CNT_clr_with_ovf", 64'(c1), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
